// File: rtl/stopwatch_counter.sv
// Stopwatch IDLE/RUN/PAUSE control with BCD mm:ss tick counter; lap-hold display via STOPWATCH_LAP_HOLD_EN.
// Latency: 1 cycle from any pulse to outputs; no backpressure, every tick accepted in RUN is counted.
module stopwatch_counter #(
  parameter int MAX_MINUTES = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       second_tick,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic       timer_enable,
  output logic       running,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       rollover
);

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MINUTES % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       rollover_q, rollover_d;
  logic       tick_acc;

  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    rollover_d = 1'b0;
    tick_acc   = second_tick && (state_q == RUN);

    if (clear) begin
      state_d    = IDLE;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else begin
      case (state_q)
        IDLE:    if (start_stop) state_d = RUN;
        RUN:     if (start_stop) state_d = PAUSE;
        PAUSE:   if (start_stop) state_d = RUN;
        default: state_d = IDLE;
      endcase

      // Tick is judged on the pre-edge state, so a RUN->PAUSE edge still counts it.
      if (tick_acc) begin
        if (sec_ones_q != 4'd9) begin
          sec_ones_d = sec_ones_q + 4'd1;
        end else begin
          sec_ones_d = 4'd0;
          if (sec_tens_q != 4'd5) begin
            sec_tens_d = sec_tens_q + 4'd1;
          end else begin
            sec_tens_d = 4'd0;
            if (min_tens_q == MAX_MIN_TENS && min_ones_q == MAX_MIN_ONES) begin
              min_ones_d = 4'd0;
              min_tens_d = 4'd0;
              rollover_d = 1'b1;
            end else if (min_ones_q == 4'd9) begin
              min_ones_d = 4'd0;
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_ones_d = min_ones_q + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      rollover_q <= rollover_d;
    end
  end

  assign running      = (state_q == RUN);
  assign timer_enable = (state_q == RUN);
  assign rollover     = rollover_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       hold_q, hold_d;
  logic [3:0] snap_so_q, snap_so_d;
  logic [3:0] snap_st_q, snap_st_d;
  logic [3:0] snap_mo_q, snap_mo_d;
  logic [3:0] snap_mt_q, snap_mt_d;

  always_comb begin
    hold_d    = hold_q;
    snap_so_d = snap_so_q;
    snap_st_d = snap_st_q;
    snap_mo_d = snap_mo_q;
    snap_mt_d = snap_mt_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap && state_q != IDLE) begin
      hold_d = ~hold_q;
      // Capture the post-update count so a same-cycle tick is included.
      if (!hold_q) begin
        snap_so_d = sec_ones_d;
        snap_st_d = sec_tens_d;
        snap_mo_d = min_ones_d;
        snap_mt_d = min_tens_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= 1'b0;
      snap_so_q <= 4'd0;
      snap_st_q <= 4'd0;
      snap_mo_q <= 4'd0;
      snap_mt_q <= 4'd0;
    end else begin
      hold_q    <= hold_d;
      snap_so_q <= snap_so_d;
      snap_st_q <= snap_st_d;
      snap_mo_q <= snap_mo_d;
      snap_mt_q <= snap_mt_d;
    end
  end

  assign sec_ones = hold_q ? snap_so_q : sec_ones_q;
  assign sec_tens = hold_q ? snap_st_q : sec_tens_q;
  assign min_ones = hold_q ? snap_mo_q : min_ones_q;
  assign min_tens = hold_q ? snap_mt_q : min_tens_q;
`else
  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
`endif

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Downstream consumer of the one-second tick generator.
- Holds the stopwatch's start/stop/clear state machine and drives the tick generator's enable.
- Counts received ticks into BCD seconds and minutes for the 7-segment display driver.
- Button inputs arrive already debounced and edge-detected, as single-cycle pulses.

Parameters:
- MAX_MINUTES, 59, highest minute value before wrap; legal range 1..99.

Ports:
- clk  input  1  system clock, same domain as the tick generator.
- rst  input  1  synchronous, active-high reset.
- start_stop  input  1  one-cycle pulse; toggles counting.
- clear  input  1  one-cycle pulse; returns to zero and idle.
- second_tick  input  1  one-cycle pulse from the tick generator.
- timer_enable  output  1  drives the tick generator's enable input.
- running  output  1  high while in the RUN state.
- sec_ones  output  4  BCD seconds units, 0..9.
- sec_tens  output  4  BCD seconds tens, 0..5.
- min_ones  output  4  BCD minutes units, 0..9.
- min_tens  output  4  BCD minutes tens, 0..9.
- rollover  output  1  one-cycle pulse on wrap from MAX_MINUTES:59 to 00:00.

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-high; single clock clk.
  - On rst=1 at a clk edge: state=IDLE; all digits=0; timer_enable=0; running=0; rollover=0.
  - rst overrides every other input.
- States: IDLE, RUN, PAUSE.
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - Any state + clear -> IDLE, with digits zeroed on the same edge.
- Priority: rst > clear > start_stop.
  - clear and start_stop in the same cycle: clear wins; start_stop is ignored.
- Outputs timer_enable and running:
  - Both equal (state==RUN), decoded directly from the state register; no extra flop.
  - Both go high the cycle after the start_stop edge.
- Tick acceptance:
  - second_tick is counted only when the current (pre-edge) state is RUN.
  - Ticks in IDLE or PAUSE are dropped.
  - Tick and start_stop in the same RUN cycle: the tick is counted, then the state goes to PAUSE.
  - Tick and start_stop in PAUSE: the tick is dropped, then the state goes to RUN.
  - Tick and clear in the same cycle: clear wins; digits become 0.
- Counting on an accepted tick (registered; visible the cycle after the tick):
  - sec_ones increments; at 9 it wraps to 0 and carries to sec_tens.
  - sec_tens wraps 5 -> 0 and carries to minutes.
  - Minutes are held as BCD pair min_tens:min_ones and increment with BCD carry (x9 -> (x+1)0).
  - At minutes == MAX_MINUTES with a carry in, all four digits go to 0 and rollover pulses for exactly one cycle, aligned with the digits showing 00:00.
  - Counting continues in RUN after a rollover.
- Latency:
  - start_stop to timer_enable change: 1 cycle.
  - second_tick to digit update: 1 cycle.
  - Every tick is counted; none is lost at carries.
- Digit hold:
  - Digits never exceed BCD range (sec_tens ≤ 5).
  - Digits hold their value in PAUSE.
  - Digits are 0 in IDLE.
- Tick generator interaction:
  - The tick generator's cycle count is not cleared when enable drops.
  - After a pause, the first tick may arrive less than one second after resume. This is accepted behaviour; the block does not compensate.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Adds port lap (input, 1-bit pulse) and adds internal snapshot registers for the four digits plus a hold flag.
  - lap in RUN or PAUSE toggles hold.
  - Setting hold captures the live digits; the captured value is the post-update value if a tick is accepted in the same cycle.
  - While hold=1, the digit outputs show the snapshot; live counting, rollover and state are unaffected.
  - clear or rst forces hold=0.
  - lap in IDLE is ignored.
  - lap and clear in the same cycle: clear wins.
- Undefined: no lap port, no snapshot registers; outputs always show the live count.

Test Plan:
- rst then start_stop, 3 ticks -> timer_enable=1 one cycle after start_stop; digits 00:03.
- From 00:59, one tick -> 01:00 next cycle. From 09:59, one tick -> 10:00.
- MAX_MINUTES=59, preload to 59:59 via ticks, one tick -> 00:00; rollover high exactly 1 cycle; running stays 1.
- RUN at 00:05, start_stop and tick in the same cycle -> 00:06, state PAUSE, timer_enable=0. 4 ticks in PAUSE -> still 00:06. start_stop then 1 tick -> 00:07.
- RUN at 02:30, clear, start_stop and tick in the same cycle -> IDLE, 00:00, timer_enable=0. rst asserted mid-RUN -> all outputs 0 next cycle.
- STOPWATCH_LAP_HOLD_EN: at 00:10, lap, then 5 ticks -> outputs show 00:10. lap again -> 00:15. clear while held -> 00:00 with hold released.
